baud_tick_gen: RTL
==================

# baud_tick_gen

Parametrised UART baud-rate tick generator with a runtime-programmable, fractional divisor. It produces an oversample tick (`os_tick`), a bit-rate tick (`bit_tick`) and the current oversample phase, which feed the UART RX and TX engines in the pen-plotter FPGA. It supports glitch-free divisor reloads at tick boundaries and a restart input that lets RX re-align the phase on a start-bit edge.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `DEFAULT_BAUD`, 115200, baud rate loaded at reset.
- `OVERSAMPLE`, 16, number of `os_tick` pulses per bit; must be a power of two and at least 4.
- `DIV_W`, 16, width of the integer divisor.
- `FRAC_BITS`, 4, width of the fractional divisor.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; while low, all state holds.
- `restart`  in  1  synchronous clear of counter, accumulator and phase.
- `div_int`  in  DIV_W  integer clocks per `os_tick`.
- `div_frac`  in  FRAC_BITS  fractional clocks per `os_tick`, in units of 2^-FRAC_BITS.
- `div_load`  in  1  one-cycle strobe that captures `div_int` and `div_frac` into the shadow register.
- `div_pending`  out  1  a shadow value is waiting to be applied.
- `os_tick`  out  1  one-cycle oversample pulse.
- `bit_tick`  out  1  one-cycle pulse, asserted together with the `os_tick` that wraps the phase.
- `os_phase`  out  $clog2(OVERSAMPLE)  index of the most recent `os_tick` (0..OVERSAMPLE-1).

## Operation
- Active divisor registers: `act_int` and `act_frac`. Reset value = `DEFAULT_DIV = round(CLK_HZ * 2^FRAC_BITS / (DEFAULT_BAUD * OVERSAMPLE))`, split into integer and fraction. With the defaults this is 868, i.e. `act_int` = 54, `act_frac` = 4.
- Period counter `cnt` is DIV_W+1 bits wide and is never allowed to overflow. Each enabled cycle:
  - if `cnt == period-1`: `cnt` becomes 0 and a tick is issued;
  - otherwise `cnt` increments by 1.
- Period computation, performed at each wrap ("boundary"):
  - `{carry, acc} = acc + act_frac`;
  - `period = act_int + carry`.
  - Result: every 2^FRAC_BITS ticks contain exactly `act_frac` stretched periods.
- Divisor clamp: `div_int` values below 2 are clamped to 2 on load. `div_frac` is taken as-is.
- Reload handshake:
  - `div_load` writes the shadow register and sets `div_pending`.
  - At the next boundary, the shadow is copied to `act_*` and `div_pending` clears.
  - A second `div_load` before that boundary overwrites the shadow (last write wins).
- Phase tracking:
  - `os_phase` increments on every `os_tick` and wraps from OVERSAMPLE-1 to 0.
  - `bit_tick` asserts on the `os_tick` that leaves `os_phase` at 0.
- `restart` has priority over `en`:
  - `cnt`, `acc` and `os_phase` are cleared; no tick is issued that cycle.
  - A pending shadow value is applied immediately, and `div_pending` clears.
- `en` low: `cnt`, `acc` and `os_phase` hold, and the tick outputs are 0. `div_load` is still accepted, and `div_pending` stays high until the next boundary after `en` returns.

## Timing
- Reset values: `os_tick` = 0, `bit_tick` = 0, `os_phase` = 0, `div_pending` = 0, `cnt` = 0, `acc` = 0, active divisor = `DEFAULT_DIV`.
- All outputs are registered. `os_tick` is high in the cycle after the edge where `cnt == period-1` is sampled.
- Tick spacing:
  - with `act_frac` = 0, `os_tick` pulses are exactly `act_int` cycles apart;
  - otherwise spacing alternates between `act_int` and `act_int+1`.
- First `os_tick` after reset release or `restart` arrives on the `period`-th enabled rising edge.
- `div_load` asserted in a boundary cycle: the value becomes active at the following boundary. It never affects the period currently being counted.
- `div_load` and `restart` in the same cycle: the new value is active for the very first period after the restart.
- Reset asserted mid-period: everything returns to reset values asynchronously, and no partial tick is emitted.

## Configuration
- `BAUD_FRAC_EN` defined: the fractional accumulator is present, `div_frac` is honoured, and `DEFAULT_DIV` carries FRAC_BITS fraction bits.
- `BAUD_FRAC_EN` undefined:
  - `acc` and `act_frac` are removed and `div_frac` is ignored;
  - `period = act_int`;
  - default `act_int = round(CLK_HZ / (DEFAULT_BAUD * OVERSAMPLE))`, which is 54 with the defaults.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_HZ_DEFAULT`;
  - the `calc_baud_div(clk_hz, baud, os, frac_bits)` function;
  - the typedef `baud_div_t` (struct of `int_part` and `frac_part`), also used by the UART register block.
- One sub-module, `baud_frac_acc`: the fractional accumulator and period computation. It is instantiated only under `BAUD_FRAC_EN`.

## Test plan
- Defaults, `en`=1, no loads, 16×16 ticks → 16 `os_tick` pulses in exactly 868 cycles; `bit_tick` every 868 cycles; `os_phase` sequence 1..15,0.
- `div_load` with `div_int`=10, `div_frac`=0, issued mid-period → current period unchanged; `div_pending` high until the next boundary; then ticks every 10 cycles.
- `div_int`=1 loaded → clamped; ticks every 2 cycles. Then `div_int`=5, `div_frac`=8 → spacings alternate 5,6; 16 ticks in 88 cycles.
- `restart` pulsed with `os_phase`=7, mid-period → `os_phase`=0 and `cnt`=0 next cycle; next `os_tick` exactly `period` cycles later; no `bit_tick` emitted.
- `en` held low for 20 cycles mid-period, with a `div_load` during that time → no ticks and state frozen; the period resumes on the remaining count; the new divisor is applied at the next boundary.
- Async `rst` asserted between clock edges with `os_phase`=12 → all outputs 0 immediately; after release, first `os_tick` on the 54th/55th edge per the default divisor.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks (baud generator, register block).
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int CLK_HZ_DEFAULT  = 100_000_000;
  localparam int BAUD_DIV_INT_W  = 16;
  localparam int BAUD_DIV_FRAC_W = 4;

  // Divisor as seen by software: integer clocks plus 2^-FRAC fractional clocks.
  typedef struct packed {
    logic [BAUD_DIV_INT_W-1:0]  int_part;
    logic [BAUD_DIV_FRAC_W-1:0] frac_part;
  } baud_div_t;

  // round(clk_hz * 2^frac_bits / (baud * os)); result carries frac_bits fraction bits.
  // Intermediates are 64-bit so large clocks with many fraction bits do not overflow.
  function automatic int calc_baud_div(int clk_hz, int baud, int os, int frac_bits);
    longint num;
    longint den;
    num = longint'(clk_hz) << frac_bits;
    den = longint'(baud) * longint'(os);
    return int'((num + den / 2) / den);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional phase accumulator; stretches a period by one clock on carry.
// Latency: period_o is combinational from the accumulator and active divisor.
// Backpressure: none; the accumulator only advances on step_i and clears on clr_i.
// Ports: clk_i/rst_i (async, active-high), step_i (period boundary), clr_i (re-align),
//        act_int_i/act_frac_i (active divisor), period_o (length of the period being counted).
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int FRAC_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 step_i,
  input  logic                 clr_i,
  input  logic [DIV_W-1:0]     act_int_i,
  input  logic [FRAC_BITS-1:0] act_frac_i,
  output logic [DIV_W:0]       period_o
);

  logic [FRAC_BITS-1:0] acc_q;
  logic [FRAC_BITS-1:0] acc_d;
  logic [FRAC_BITS:0]   sum;

  // The carry out of acc + frac decides the stretch for the period currently
  // being counted; acc itself only moves on at the boundary that ends it.
  assign sum      = {1'b0, acc_q} + {1'b0, act_frac_i};
  assign period_o = {1'b0, act_int_i} + {{DIV_W{1'b0}}, sum[FRAC_BITS]};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = sum[FRAC_BITS-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART baud tick generator with runtime divisor and oversample phase.
// Latency: all outputs registered; os_tick is high the cycle after the wrap edge.
// Backpressure: none; en low freezes counting, restart re-aligns, div_load is always accepted.
// Ports: clk/rst (async, active-high), en, restart, div_int/div_frac/div_load (shadow write),
//        div_pending (shadow waiting), os_tick, bit_tick, os_phase.
// Config: define BAUD_FRAC_EN to include the fractional accumulator and honour div_frac.
//         OVERSAMPLE must be a power of two (phase wraps by natural overflow).
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int DEFAULT_BAUD = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_BITS    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          restart,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_BITS-1:0]          div_frac,
  input  logic                          div_load,
  output logic                          div_pending,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int CW   = DIV_W + 1;

`ifdef BAUD_FRAC_EN
  localparam int DEFAULT_DIV = calc_baud_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE, FRAC_BITS);
  localparam logic [DIV_W-1:0]     DEFAULT_INT  = DIV_W'(DEFAULT_DIV >> FRAC_BITS);
  localparam logic [FRAC_BITS-1:0] DEFAULT_FRAC = FRAC_BITS'(DEFAULT_DIV);
`else
  localparam int DEFAULT_DIV = calc_baud_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE, 0);
  localparam logic [DIV_W-1:0]     DEFAULT_INT  = DIV_W'(DEFAULT_DIV);
`endif

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] sh_int_q, sh_int_d;
  logic [DIV_W-1:0] act_int_q, act_int_d;
  logic [DIV_W-1:0] load_int;
  logic [CW-1:0]    period;
  logic             wrap;

  // A divisor below 2 would make the counter wrap every cycle, so clamp it on entry.
  assign load_int = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;

`ifdef BAUD_FRAC_EN
  logic [FRAC_BITS-1:0] sh_frac_q, sh_frac_d;
  logic [FRAC_BITS-1:0] act_frac_q, act_frac_d;

  baud_frac_acc #(
    .DIV_W     (DIV_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_frac_acc (
    .clk_i      (clk),
    .rst_i      (rst),
    .step_i     (wrap),
    .clr_i      (restart),
    .act_int_i  (act_int_q),
    .act_frac_i (act_frac_q),
    .period_o   (period)
  );
`else
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
  assign period          = {1'b0, act_int_q};
`endif

  // restart wins over en, so a boundary can never coincide with a restart.
  assign wrap = en && !restart && (cnt_q == period - CW'(1));

  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    pend_d     = pend_q;
    sh_int_d   = sh_int_q;
    act_int_d  = act_int_q;
`ifdef BAUD_FRAC_EN
    sh_frac_d  = sh_frac_q;
    act_frac_d = act_frac_q;
`endif
    if (restart) begin
      cnt_d   = '0;
      phase_d = '0;
      pend_d  = 1'b0;
      // A load in the restart cycle bypasses the shadow so it governs the first period.
      if (div_load) begin
        act_int_d  = load_int;
`ifdef BAUD_FRAC_EN
        act_frac_d = div_frac;
`endif
      end else if (pend_q) begin
        act_int_d  = sh_int_q;
`ifdef BAUD_FRAC_EN
        act_frac_d = sh_frac_q;
`endif
      end
    end else begin
      if (wrap) begin
        cnt_d      = '0;
        os_tick_d  = 1'b1;
        phase_d    = phase_q + PH_W'(1);
        bit_tick_d = &phase_q;
        // The shadow as it stood before this edge is applied; a load on this
        // same edge stays pending for the following boundary.
        if (pend_q) begin
          act_int_d  = sh_int_q;
`ifdef BAUD_FRAC_EN
          act_frac_d = sh_frac_q;
`endif
          pend_d     = 1'b0;
        end
      end else if (en) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (div_load) begin
        sh_int_d  = load_int;
`ifdef BAUD_FRAC_EN
        sh_frac_d = div_frac;
`endif
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      pend_q     <= 1'b0;
      sh_int_q   <= DEFAULT_INT;
      act_int_q  <= DEFAULT_INT;
`ifdef BAUD_FRAC_EN
      sh_frac_q  <= DEFAULT_FRAC;
      act_frac_q <= DEFAULT_FRAC;
`endif
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      pend_q     <= pend_d;
      sh_int_q   <= sh_int_d;
      act_int_q  <= act_int_d;
`ifdef BAUD_FRAC_EN
      sh_frac_q  <= sh_frac_d;
      act_frac_q <= act_frac_d;
`endif
    end
  end

  assign os_tick     = os_tick_q;
  assign bit_tick    = bit_tick_q;
  assign os_phase    = phase_q;
  assign div_pending = pend_q;

endmodule
